// File: rtl/rr_sched_pkg.sv
// Shared types, defaults and bit helpers for round_robin_scheduler.
// Optional grant timeout is enabled by defining RR_SCHED_TIMEOUT_EN.
package rr_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int N_REQ_DEF   = 8;
  localparam int TIMEOUT_DEF = 255;

  function automatic logic [31:0] lowest_set_bit(
    input logic [31:0] v
  );
    return v & (~v + 32'd1);
  endfunction

  function automatic logic [4:0] onehot_to_idx(
    input logic [31:0] oh
  );
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/round_robin_scheduler_if.sv
// Request/grant bundle between channel front-ends and the scheduler.
// timeout_pulse exists only when RR_SCHED_TIMEOUT_EN is defined.
interface round_robin_scheduler_if
  import rr_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) ();

  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

`ifdef RR_SCHED_TIMEOUT_EN
  logic             timeout_pulse;

  modport master (
    output req, done,
    input  grant, grant_valid, grant_idx,
    input  timeout_pulse
  );

  modport slave (
    input  req, done,
    output grant, grant_valid, grant_idx,
    output timeout_pulse
  );
`else
  modport master (
    output req, done,
    input  grant, grant_valid, grant_idx
  );

  modport slave (
    input  req, done,
    output grant, grant_valid, grant_idx
  );
`endif

endinterface

// File: rtl/round_robin_scheduler_thermo_mask.sv
// Prefix-OR of a one-hot vector: bit i set when the hot bit is at i or above.
// Independent of RR_SCHED_TIMEOUT_EN.
module thermo_mask #(
  parameter int N = 8
) (
  input  logic [N-1:0] oh_i,
  output logic [N-1:0] mask_o
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign mask_o[i] = |oh_i[N-1:i];
  end

endmodule

// File: rtl/round_robin_scheduler.sv
// Round-robin owner scheduler for one shared datapath, registered one-hot grant.
// Define RR_SCHED_TIMEOUT_EN to force-release grants held TIMEOUT_CYCLES.
module round_robin_scheduler
  import rr_sched_pkg::*;
#(
  parameter int N_REQ          = N_REQ_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  round_robin_scheduler_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("round_robin_scheduler: bad N_REQ/TIMEOUT_CYCLES");
  end

  localparam logic [N_REQ-1:0] LAST_RST =
    {1'b1, {(N_REQ-1){1'b0}}};

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] pick_src;
  logic [31:0]      win32;
  logic [N_REQ-1:0] win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             owner_done;

  thermo_mask #(
    .N (N_REQ)
  ) u_mask (
    .oh_i   (last_q),
    .mask_o (mask)
  );

  // Wrap to the full request vector when nobody sits above the last owner.
  assign masked   = bus.req & ~mask;
  assign pick_src = (|masked) ? masked : bus.req;
  assign win32    = lowest_set_bit(32'(pick_src));
  assign win_oh   = win32[N_REQ-1:0];
  assign win_idx  = IDX_W'(onehot_to_idx(win32));

  assign owner_done = |(bus.done & grant_q);

`ifdef RR_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             hit;

  assign hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    idx_d   = idx_q;
`ifdef RR_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = win_oh;
          last_d  = win_oh;
          idx_d   = win_idx;
          state_d = BUSY;
`ifdef RR_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
`ifdef RR_SCHED_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
        if (owner_done || hit) begin
          grant_d = '0;
          idx_d   = '0;
          state_d = IDLE;
          to_d    = hit && !owner_done;
        end
`else
        if (owner_done) begin
          grant_d = '0;
          idx_d   = '0;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
    end
  end

`ifdef RR_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign bus.timeout_pulse = to_q;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_valid = (state_q == BUSY);
  assign bus.grant_idx   = idx_q;

endmodule

// File: tb/tb_round_robin_scheduler.sv
// Directed bench for round_robin_scheduler (N_REQ=8).
// Timeout sequence runs only when RR_SCHED_TIMEOUT_EN is defined.
module tb_round_robin_scheduler;

  localparam int N  = 8;
  localparam int TO = 4;

  typedef struct {
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] grant;
    logic       valid;
    logic [2:0] idx;
    string      name;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  round_robin_scheduler_if #(.N_REQ(N)) bus ();

  round_robin_scheduler #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_out(
    input string      name,
    input logic [7:0] g,
    input logic       v,
    input logic [2:0] i
  );
    check({name, ".grant"}, 32'(bus.grant), 32'(g));
    check({name, ".valid"}, 32'(bus.grant_valid), 32'(v));
    check({name, ".idx"}, 32'(bus.grant_idx), 32'(i));
  endtask

  task automatic step(input vec_t v);
    bus.req  = v.req;
    bus.done = v.done;
    @(posedge clk);
    #1;
    check_out(v.name, v.grant, v.valid, v.idx);
  endtask

  vec_t tab_a[4];
  vec_t tab_c[5];
  vec_t v;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = '0;

    tab_a[0] = '{8'hA0, 8'h00, 8'h20, 1'b1, 3'd5, "first_grant"};
    tab_a[1] = '{8'h21, 8'h20, 8'h00, 1'b0, 3'd0, "release5"};
    tab_a[2] = '{8'h21, 8'h00, 8'h01, 1'b1, 3'd0, "wrap_to0"};
    tab_a[3] = '{8'hFF, 8'h01, 8'h00, 1'b0, 3'd0, "release0"};

    tab_c[0] = '{8'h08, 8'h00, 8'h08, 1'b1, 3'd3, "grant3"};
    tab_c[1] = '{8'h00, 8'h40, 8'h08, 1'b1, 3'd3, "other_done"};
    tab_c[2] = '{8'h00, 8'h00, 8'h08, 1'b1, 3'd3, "req_dropped"};
    tab_c[3] = '{8'h00, 8'h08, 8'h00, 1'b0, 3'd0, "done3"};
    tab_c[4] = '{8'h00, 8'h08, 8'h00, 1'b0, 3'd0, "done_idle"};

    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 8'h00, 1'b0, 3'd0);
`ifdef RR_SCHED_TIMEOUT_EN
    check("reset.tpulse", 32'(bus.timeout_pulse), 32'd0);
`endif
    rst = 1'b0;
    v = '{8'h00, 8'h00, 8'h00, 1'b0, 3'd0, "idle_noreq"};
    step(v);

    for (int i = 0; i < 4; i++) step(tab_a[i]);

    // Rotation with everyone requesting: 1..7 then back to 0.
    for (int i = 1; i <= 8; i++) begin
      int k;
      k = i % 8;
      v = '{8'hFF, 8'h00, 8'(1 << k), 1'b1, 3'(k), "rot_grant"};
      step(v);
      v = '{8'hFF, 8'(1 << k), 8'h00, 1'b0, 3'd0, "rot_gap"};
      step(v);
    end

    for (int i = 0; i < 5; i++) step(tab_c[i]);

    v = '{8'h40, 8'h00, 8'h40, 1'b1, 3'd6, "grant6"};
    step(v);
    #1 rst = 1'b1;
    #1;
    check_out("async_rst", 8'h00, 1'b0, 3'd0);
    #1 rst = 1'b0;
    v = '{8'hFF, 8'h00, 8'h01, 1'b1, 3'd0, "post_rst"};
    step(v);

`ifdef RR_SCHED_TIMEOUT_EN
    v = '{8'h00, 8'h01, 8'h00, 1'b0, 3'd0, "to_rel0"};
    step(v);
    v = '{8'h04, 8'h00, 8'h04, 1'b1, 3'd2, "to_grant2"};
    step(v);
    for (int i = 0; i < 3; i++) begin
      v = '{8'h0C, 8'h00, 8'h04, 1'b1, 3'd2, "to_hold"};
      step(v);
      check("to_hold.tpulse", 32'(bus.timeout_pulse), 32'd0);
    end
    v = '{8'h0C, 8'h00, 8'h00, 1'b0, 3'd0, "to_drop"};
    step(v);
    check("to_drop.tpulse", 32'(bus.timeout_pulse), 32'd1);
    v = '{8'h0C, 8'h00, 8'h08, 1'b1, 3'd3, "to_next3"};
    step(v);
    check("to_next3.tpulse", 32'(bus.timeout_pulse), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
